ctrl_apb_master: RTL and testbench

Control-plane APB master sequencer. Accepts single-beat register read/write commands from `NUM_REQ` requesters (requester 0 is the PCIe host mailbox, requester 1 is the JTAG debug bridge) and arbitrates between them round-robin. It decodes the target slot from the address and runs one APB SETUP/ACCESS transfer on one of 16 slave slots, then returns read data and error status to the granted requester. It replaces the tied-off APB drive in the control plane.

---
 rtl/ctrl_apb_master.sv | 218 +++++++++++++++++++++
 tb/tb_ctrl_apb_master.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_apb_master.sv
// Control-plane APB master: round-robin arbitration over NUM_REQ requesters, one SETUP/ACCESS transfer on a decoded slot.
// Optional ACCESS timeout is enabled by defining RV_P4_APB_TIMEOUT_EN.
module ctrl_apb_master #(
    parameter int NUM_REQ     = 2,
    parameter int NUM_SLOTS   = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                   clk_ctrl,
    input  logic                   rst_ctrl_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ-1:0]     req_write,
    input  logic [NUM_REQ*32-1:0]  req_addr,
    input  logic [NUM_REQ*32-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic [NUM_SLOTS-1:0]   psel,
    output logic                   penable,
    output logic                   pwrite,
    output logic [31:0]            paddr,
    output logic [31:0]            pwdata,
    input  logic [NUM_SLOTS*32-1:0] prdata,
    input  logic [NUM_SLOTS-1:0]   pready,
    input  logic [NUM_SLOTS-1:0]   pslverr,
    output logic                   busy,
    output logic [15:0]            err_cnt
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t           state_reg, state_next;
    logic [ID_W-1:0]  id_reg, id_next;
    logic [ID_W-1:0]  last_grant_reg, last_grant_next;
    logic [3:0]       slot_reg, slot_next;
    logic             pwrite_reg, pwrite_next;
    logic [31:0]      paddr_reg, paddr_next;
    logic [31:0]      pwdata_reg, pwdata_next;
    logic [31:0]      rdata_reg, rdata_next;
    logic             err_reg, err_next;
    logic [15:0]      err_cnt_reg, err_cnt_next;

    logic [31:0]      addr_arr  [NUM_REQ];
    logic [31:0]      wdata_arr [NUM_REQ];
    logic [31:0]      prdata_arr [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] slot_oh;
    logic             in_xfer;

    logic             grant_found;
    logic [ID_W-1:0]  grant_id;
    logic             sel_write;
    logic [31:0]      sel_addr, sel_wdata;
    logic             dec_err;
    logic             cur_pready, cur_pslverr;
    logic [31:0]      cur_prdata;
    logic             tmo_hit;

    assign in_xfer = (state_reg == SETUP) || (state_reg == ACCESS);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign addr_arr[gi]  = req_addr[gi*32 +: 32];
            assign wdata_arr[gi] = req_wdata[gi*32 +: 32];
            assign req_ready[gi] = (state_reg == IDLE) && grant_found && (grant_id == ID_W'(gi));
            assign rsp_valid[gi] = (state_reg == RESP) && (id_reg == ID_W'(gi));
        end
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            assign prdata_arr[gi] = prdata[gi*32 +: 32];
            assign slot_oh[gi]    = (slot_reg == 4'(gi));
            assign psel[gi]       = in_xfer && slot_oh[gi];
        end
    endgenerate

    // Round-robin: priority k=1 is the requester just after last_grant, so the last winner comes last.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        sel_write   = 1'b0;
        sel_addr    = '0;
        sel_wdata   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!grant_found && req_valid[j] && (j == (int'(last_grant_reg) + k) % NUM_REQ)) begin
                    grant_found = 1'b1;
                    grant_id    = ID_W'(j);
                    sel_write   = req_write[j];
                    sel_addr    = addr_arr[j];
                    sel_wdata   = wdata_arr[j];
                end
            end
        end
    end

    assign dec_err     = (|sel_addr[31:20]) || ({28'd0, sel_addr[19:16]} >= 32'(NUM_SLOTS));
    assign cur_pready  = |(pready & slot_oh);
    assign cur_pslverr = |(pslverr & slot_oh);

    always_comb begin
        cur_prdata = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (slot_oh[s]) cur_prdata = cur_prdata | prdata_arr[s];
        end
    end

`ifdef RV_P4_APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;

    // Counter holds the number of ACCESS cycles already completed.
    always_comb begin
        tmo_cnt_next = tmo_cnt_reg;
        if (state_reg == SETUP)       tmo_cnt_next = '0;
        else if (state_reg == ACCESS) tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
    end

    always_ff @(posedge clk_ctrl or negedge rst_ctrl_n) begin
        if (!rst_ctrl_n) tmo_cnt_reg <= '0;
        else             tmo_cnt_reg <= tmo_cnt_next;
    end

    assign tmo_hit = (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_next      = state_reg;
        id_next         = id_reg;
        last_grant_next = last_grant_reg;
        slot_next       = slot_reg;
        pwrite_next     = pwrite_reg;
        paddr_next      = paddr_reg;
        pwdata_next     = pwdata_reg;
        rdata_next      = rdata_reg;
        err_next        = err_reg;
        err_cnt_next    = err_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (grant_found) begin
                    id_next   = grant_id;
                    slot_next = sel_addr[19:16];
                    if (dec_err) begin
                        state_next = RESP;
                        err_next   = 1'b1;
                        rdata_next = '0;
                    end else begin
                        state_next  = SETUP;
                        pwrite_next = sel_write;
                        paddr_next  = {16'h0, sel_addr[15:0]};
                        pwdata_next = sel_wdata;
                    end
                end
            end
            SETUP: state_next = ACCESS;
            ACCESS: begin
                // pready wins over a timeout landing in the same cycle
                if (cur_pready || tmo_hit) begin
                    state_next  = RESP;
                    pwrite_next = 1'b0;
                    paddr_next  = '0;
                    pwdata_next = '0;
                    if (cur_pready) begin
                        err_next   = cur_pslverr;
                        rdata_next = (!pwrite_reg && !cur_pslverr) ? cur_prdata : 32'd0;
                    end else begin
                        err_next   = 1'b1;
                        rdata_next = '0;
                    end
                end
            end
            RESP: begin
                state_next      = IDLE;
                last_grant_next = id_reg;
                err_next        = 1'b0;
                rdata_next      = '0;
                if (err_reg && (err_cnt_reg != 16'hFFFF)) err_cnt_next = err_cnt_reg + 16'd1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_ctrl or negedge rst_ctrl_n) begin
        if (!rst_ctrl_n) begin
            state_reg      <= IDLE;
            id_reg         <= '0;
            last_grant_reg <= ID_W'(NUM_REQ - 1);
            slot_reg       <= '0;
            pwrite_reg     <= 1'b0;
            paddr_reg      <= '0;
            pwdata_reg     <= '0;
            rdata_reg      <= '0;
            err_reg        <= 1'b0;
            err_cnt_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            id_reg         <= id_next;
            last_grant_reg <= last_grant_next;
            slot_reg       <= slot_next;
            pwrite_reg     <= pwrite_next;
            paddr_reg      <= paddr_next;
            pwdata_reg     <= pwdata_next;
            rdata_reg      <= rdata_next;
            err_reg        <= err_next;
            err_cnt_reg    <= err_cnt_next;
        end
    end

    assign penable   = (state_reg == ACCESS);
    assign pwrite    = pwrite_reg;
    assign paddr     = paddr_reg;
    assign pwdata    = pwdata_reg;
    assign rsp_rdata = (state_reg == RESP) ? rdata_reg : 32'd0;
    assign rsp_err   = (state_reg == RESP) && err_reg;
    assign busy      = (state_reg != IDLE);
    assign err_cnt   = err_cnt_reg;
endmodule

// File: tb/tb_ctrl_apb_master.sv
// Directed bench for ctrl_apb_master: zero/wait-state transfers, arbitration, errors, timeout and mid-transfer reset.
module tb_ctrl_apb_master;
    localparam int NR = 2;
    localparam int NS = 16;
    localparam int TCYC = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NR-1:0]      req_valid, req_ready, req_write, rsp_valid;
    logic [NR*32-1:0]   req_addr, req_wdata;
    logic [31:0]        rsp_rdata, paddr, pwdata;
    logic               rsp_err, penable, pwrite, busy;
    logic [NS-1:0]      psel, pready, pslverr;
    logic [NS*32-1:0]   prdata;
    logic [15:0]        err_cnt;
    int                 checks = 0;
    int                 errors = 0;

    always #5 clk = ~clk;

    ctrl_apb_master #(.NUM_REQ(NR), .NUM_SLOTS(NS), .TIMEOUT_CYC(TCYC)) dut (
        .clk_ctrl(clk), .rst_ctrl_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .busy(busy), .err_cnt(err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic wr, input logic [31:0] a, input logic [31:0] d);
        req_write[r]          = wr;
        req_addr[r*32 +: 32]  = a;
        req_wdata[r*32 +: 32] = d;
        req_valid[r]          = 1'b1;
    endtask

    initial begin
        int waited;
        rst_n = 1'b0;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        pready = '1; pslverr = '0; prdata = '0;
        step(); step();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_psel", 32'(psel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_paddr", paddr, 32'd0);
        rst_n = 1'b1;
        step();

        // req0 zero-wait write to slot 3
        set_req(0, 1'b1, 32'h0003_0010, 32'hA5A5_0001);
        #1;
        check("wr_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = '0;
        check("wr_setup_psel", 32'(psel), 32'h0000_0008);
        check("wr_setup_penable", 32'(penable), 32'd0);
        check("wr_setup_pwrite", 32'(pwrite), 32'd1);
        step();
        check("wr_access_penable", 32'(penable), 32'd1);
        check("wr_access_paddr", paddr, 32'h0000_0010);
        check("wr_access_pwdata", pwdata, 32'hA5A5_0001);
        step();
        check("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        check("wr_rsp_err", 32'(rsp_err), 32'd0);
        check("wr_rsp_psel", 32'(psel), 32'd0);
        check("wr_rsp_paddr", paddr, 32'd0);
        step();
        check("wr_idle_busy", 32'(busy), 32'd0);
        $display("txn req0 write 0x00030010 <= 0xa5a50001");

        // req1 read slot 15 with 3 wait states
        prdata[15*32 +: 32] = 32'h1234_5678;
        set_req(1, 1'b0, 32'h000F_0004, 32'h0);
        #1;
        check("rd_ready", 32'(req_ready), 32'd2);
        step();
        req_valid = '0;
        pready[15] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rd_wait_penable", 32'(penable), 32'd1);
            check("rd_wait_rsp", 32'(rsp_valid), 32'd0);
        end
        step();
        pready[15] = 1'b1;
        step();
        check("rd_rsp_valid", 32'(rsp_valid), 32'd2);
        check("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
        check("rd_rsp_err", 32'(rsp_err), 32'd0);
        step();
        $display("txn req1 read 0x000f0004 => 0x%08h", 32'h1234_5678);

        // decode error: no APB activity, response next cycle
        set_req(0, 1'b0, 32'h0010_0000, 32'h0);
        #1;
        check("dec_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = '0;
        check("dec_rsp_valid", 32'(rsp_valid), 32'd1);
        check("dec_rsp_err", 32'(rsp_err), 32'd1);
        check("dec_rsp_rdata", rsp_rdata, 32'd0);
        check("dec_psel", 32'(psel), 32'd0);
        step();
        check("dec_err_cnt", 32'(err_cnt), 32'd1);
        check("dec_busy", 32'(busy), 32'd0);
        $display("txn req0 read 0x00100000 decode error");

        // slave error on slot 5
        pslverr[5] = 1'b1;
        prdata[5*32 +: 32] = 32'hDEAD_BEEF;
        set_req(1, 1'b0, 32'h0005_0008, 32'h0);
        #1;
        check("slverr_ready", 32'(req_ready), 32'd2);
        step();
        req_valid = '0;
        check("slverr_psel", 32'(psel), 32'h0000_0020);
        step();
        step();
        check("slverr_rsp_valid", 32'(rsp_valid), 32'd2);
        check("slverr_rsp_err", 32'(rsp_err), 32'd1);
        check("slverr_rsp_rdata", rsp_rdata, 32'd0);
        step();
        check("slverr_err_cnt", 32'(err_cnt), 32'd2);
        pslverr[5] = 1'b0;
        $display("txn req1 read 0x00050008 slave error");

        // both requesters continuously valid: grants alternate starting with req0
        set_req(0, 1'b1, 32'h0001_0000, 32'h0000_00AA);
        set_req(1, 1'b0, 32'h0002_0004, 32'h0);
        #1;
        for (int k = 0; k < 4; k++) begin
            waited = 0;
            while (req_ready == '0 && waited < 10) begin
                step();
                waited++;
            end
            check("rr_grant", 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
            step(); step(); step();
            check("rr_rsp_valid", 32'(rsp_valid), (k % 2 == 0) ? 32'd1 : 32'd2);
            step();
            $display("txn round-robin grant %0d to req%0d", k, k % 2);
        end
        req_valid = '0;
        step();

        // slot 2 never ready
        pready[2] = 1'b0;
        prdata[2*32 +: 32] = 32'hCAFE_F00D;
        set_req(0, 1'b0, 32'h0002_0000, 32'h0);
        #1;
        check("tmo_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = '0;
        check("tmo_psel", 32'(psel), 32'h0000_0004);
`ifdef RV_P4_APB_TIMEOUT_EN
        for (int i = 0; i < TCYC; i++) begin
            step();
            check("tmo_penable", 32'(penable), 32'd1);
        end
        step();
        check("tmo_end_penable", 32'(penable), 32'd0);
        check("tmo_end_psel", 32'(psel), 32'd0);
        check("tmo_rsp_valid", 32'(rsp_valid), 32'd1);
        check("tmo_rsp_err", 32'(rsp_err), 32'd1);
        check("tmo_rsp_rdata", rsp_rdata, 32'd0);
        step();
        check("tmo_err_cnt", 32'(err_cnt), 32'd3);
        $display("txn req0 read 0x00020000 timed out");
`else
        for (int i = 0; i < 20; i++) step();
        check("stall_busy", 32'(busy), 32'd1);
        check("stall_penable", 32'(penable), 32'd1);
        check("stall_rsp_valid", 32'(rsp_valid), 32'd0);
        pready[2] = 1'b1;
        waited = 0;
        while (rsp_valid == '0 && waited < 5) begin
            step();
            waited++;
        end
        check("stall_rsp_valid_end", 32'(rsp_valid), 32'd1);
        check("stall_rsp_err", 32'(rsp_err), 32'd0);
        check("stall_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
        step();
        check("stall_err_cnt", 32'(err_cnt), 32'd2);
        pready[2] = 1'b0;
        $display("txn req0 read 0x00020000 stalled then completed");
`endif

        // reset during ACCESS aborts the transfer
        set_req(1, 1'b0, 32'h0002_0000, 32'h0);
        #1;
        check("abort_ready", 32'(req_ready), 32'd2);
        step();
        req_valid = '0;
        step();
        check("abort_access_penable", 32'(penable), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_psel", 32'(psel), 32'd0);
        check("abort_penable", 32'(penable), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        rst_n = 1'b1;
        pready = '1;
        check("abort_err_cnt", 32'(err_cnt), 32'd0);
        $display("txn req1 read 0x00020000 aborted by reset");

        prdata[3*32 +: 32] = 32'h0BAD_F00D;
        set_req(0, 1'b0, 32'h0003_0000, 32'h0);
        set_req(1, 1'b0, 32'h0003_0004, 32'h0);
        #1;
        check("post_rst_grant", 32'(req_ready), 32'd1);
        step();
        req_valid = '0;
        step();
        step();
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'd1);
        check("post_rst_rdata", rsp_rdata, 32'h0BAD_F00D);
        step();
        $display("txn req0 read 0x00030000 => 0x%08h", 32'h0BAD_F00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
